crc16gen_tx: RTL and testbench
==============================

Name: crc16gen_tx

Overview:
Bit-serial CRC-16 generator and appender for the tag backscatter path. It sits between the reply-bit source (handle/RN16/read-data shifter) and the FM0/Miller encoder. Payload bits pass through unchanged while the CRC accumulates. The block then appends the ones'-complement CRC-16, MSB first. A receiver running the CRC-16 check over payload plus appended CRC ends with residue 16'h1D0F.

Parameters:
PRESET, 16'hFFFF, CRC register value loaded on reset, on start, and on abort.
POLY, 16'h1021, generator polynomial taps (x^16+x^12+x^5+1); bit k set means feedback XORs into crc[k].
INVERT, 1, when 1 the appended CRC bits are complemented; when 0 they are sent true.

Ports:
crcclk  input  1  block clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high; forces the reset state below.
start  input  1  single-cycle pulse; begins a frame (honoured only in IDLE).
abort  input  1  synchronous; returns to IDLE, presets crc, drops out_valid.
in_bit  input  1  payload bit.
in_valid  input  1  in_bit is valid.
in_last  input  1  qualifies in_bit as the final payload bit.
in_ready  output  1  block accepts a payload bit this cycle.
out_bit  output  1  serial bit to the encoder.
out_valid  output  1  out_bit is valid.
out_ready  input  1  encoder consumes out_bit this cycle.
busy  output  1  high in every state other than IDLE.
done  output  1  one-cycle pulse when the last CRC bit is consumed.
crc  output  16  running CRC register, uncomplemented.

Behaviour:
- Reset state: crc=PRESET, state=IDLE, out_bit=0, out_valid=0, in_ready=0, busy=0, done=0, bit counter=0.
- Output register: a single stage. It is "free" when !out_valid || out_ready. It loads only when free and is cleared when consumed with nothing new loaded.
- States are IDLE, DATA, CRC, DONE.
- IDLE:
  - in_ready=0.
  - start -> DATA, crc<=PRESET.
  - in_valid is ignored in IDLE.
- DATA:
  - in_ready = free.
  - Accept occurs when in_valid && in_ready.
  - On accept: out_bit<=in_bit, out_valid<=1, fb=in_bit^crc[15], crc<=(crc<<1)^(fb ? POLY : 0).
  - Latency from accept to out_valid is exactly 1 cycle.
  - Accept with in_last -> CRC, counter<=0.
- CRC:
  - in_ready=0.
  - Each cycle the register is free: out_bit<=crc[15-counter] ^ INVERT, out_valid<=1, counter++.
  - crc holds its value throughout this state.
  - After the load with counter==15 -> DONE.
- DONE:
  - When the final bit is consumed (out_valid && out_ready): out_valid<=0, done=1 for that cycle only, state -> IDLE.
  - crc keeps its final value until the next start.
- start while busy is ignored. No frame restart occurs.
- abort has priority over start and over all handshakes in the same cycle. On abort, done is not pulsed.
- Asynchronous reset mid-frame clears everything immediately. No partial CRC is emitted afterwards.
- Backpressure: out_ready=0 holds out_bit/out_valid stable, stalls in_ready, and freezes the CRC counter.
- Minimum payload is 1 bit. A frame emits exactly N+16 bits for N accepted payload bits.
- Throughput is 1 bit per cycle with out_ready held high.

Test Plan:
- ASCII "123456789" (72 bits, MSB first), out_ready=1 -> crc=16'h29B1 after the last payload bit; appended bits = 16'hD64E MSB first; 88 output bits total; done pulses once.
- Same frame fed back through the CRC-16 checker -> checker residue 16'h1D0F.
- Same frame with out_ready toggling at random -> identical 88-bit output sequence; out_bit stable while out_valid && !out_ready.
- Single payload bit 0 with in_last -> 17 output bits; first bit is 0; appended CRC equals the complement of the CRC of 1'b0 with preset FFFF; busy falls the cycle after done.
- start pulsed mid-DATA -> ignored, output unchanged; abort mid-CRC (counter=7) -> IDLE next cycle, out_valid=0, crc=16'hFFFF, no done pulse.
- reset asserted asynchronously mid-DATA between clock edges -> all outputs at reset values before the next edge; a following clean frame reproduces 16'hD64E.

Source files
------------

// File: rtl/crc16gen_tx_if.sv
// Handshake bundle between the reply-bit source, the CRC-16 appender and the line encoder.
// The master modport is the side that feeds payload bits and consumes the serial output.
interface crc16gen_tx_if;
    logic        start;
    logic        abort;
    logic        in_bit;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] crc;

    modport master (
        output start, abort, in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_bit, out_valid, busy, done, crc
    );

    modport slave (
        input  start, abort, in_bit, in_valid, in_last, out_ready,
        output in_ready, out_bit, out_valid, busy, done, crc
    );
endinterface

// File: rtl/crc16gen_tx.sv
// Bit-serial CRC-16 generator: forwards payload bits unchanged, then appends the
// (optionally complemented) CRC MSB first through a single-stage output register.
module crc16gen_tx #(
    parameter logic [15:0] PRESET = 16'hFFFF,
    parameter logic [15:0] POLY   = 16'h1021,
    parameter bit          INVERT = 1'b1
) (
    input  logic              crcclk,
    input  logic              reset,
    crc16gen_tx_if.slave      bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CRC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_crc;
    logic [3:0]  r_count;
    logic        r_outBit;
    logic        r_outValid;

    logic        w_free;
    logic        w_inReady;
    logic        w_accept;
    logic        w_consume;
    logic        w_fb;
    logic [15:0] w_crcNext;
    logic        w_crcBit;
    logic        w_done;

    // The output stage may take a new bit when empty or being drained this cycle.
    assign w_free    = !r_outValid || bus.out_ready;
    assign w_inReady = (r_state == ST_DATA) && w_free && !bus.abort;
    assign w_accept  = w_inReady && bus.in_valid;
    assign w_consume = r_outValid && bus.out_ready;
    assign w_fb      = bus.in_bit ^ r_crc[15];
    assign w_crcNext = {r_crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
    assign w_crcBit  = r_crc[4'd15 - r_count] ^ INVERT;
    assign w_done    = (r_state == ST_DONE) && w_consume && !bus.abort;

    always_ff @(posedge crcclk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_crc      <= PRESET;
            r_count    <= 4'd0;
            r_outBit   <= 1'b0;
            r_outValid <= 1'b0;
        end else if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_crc      <= PRESET;
            r_count    <= 4'd0;
            r_outBit   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_DATA;
                        r_crc   <= PRESET;
                        r_count <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_outBit   <= bus.in_bit;
                        r_outValid <= 1'b1;
                        r_crc      <= w_crcNext;
                        if (bus.in_last) begin
                            r_state <= ST_CRC;
                            r_count <= 4'd0;
                        end
                    end else if (w_free) begin
                        r_outBit   <= 1'b0;
                        r_outValid <= 1'b0;
                    end
                end
                ST_CRC: begin
                    // The CRC register is frozen here; the counter walks it MSB first.
                    if (w_free) begin
                        r_outBit   <= w_crcBit;
                        r_outValid <= 1'b1;
                        r_count    <= r_count + 4'd1;
                        if (r_count == 4'd15) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (w_consume) begin
                        r_outBit   <= 1'b0;
                        r_outValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_bit   = r_outBit;
    assign bus.out_valid = r_outValid;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = w_done;
    assign bus.crc       = r_crc;

endmodule

// File: tb/tb_crc16gen_tx.sv
// Directed bench for crc16gen_tx: table of whole frames with known CRCs plus
// hand-written abort and asynchronous-reset sequences.
module tb_crc16gen_tx;

    logic crcclk;
    logic reset;

    crc16gen_tx_if bus();

    crc16gen_tx dut (
        .crcclk (crcclk),
        .reset  (reset),
        .bus    (bus)
    );

    initial crcclk = 1'b0;
    always #5 crcclk = ~crcclk;

    typedef struct {
        logic [71:0] payload;
        int          nBits;
        bit          randReady;
        int          startMid;
        logic [15:0] expCrc;
        logic [15:0] expTail;
    } FrameVec;

    FrameVec vecs[6];
    int totalChecks = 0;
    int badChecks   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input bit iv, input bit ib, input bit il, input bit ordy);
        bus.start     = st;
        bus.abort     = ab;
        bus.in_valid  = iv;
        bus.in_bit    = ib;
        bus.in_last   = il;
        bus.out_ready = ordy;
    endtask

    // Receiver-side CRC-16 check step, used to confirm the 1D0F residue.
    function automatic logic [15:0] rxStep(input logic [15:0] c, input bit b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic runFrame(input FrameVec v, input int vecId);
        int          idx = 0;
        int          doneCount = 0;
        int          doneCyc = -1;
        int          stableErr = 0;
        bit          heldValid = 0;
        bit          heldBit = 0;
        bit          afterDone = 0;
        bit          finished = 0;
        bit          busyAtDone = 0;
        bit          busyAfter = 1;
        logic [15:0] crcAtDone = 16'h0;
        logic [15:0] residue = 16'hFFFF;
        logic [71:0] gotPay = '0;
        logic [15:0] gotTail = '0;
        bit          outQ[$];
        bit          st, ordy, ib;
        string       tag;
        tag = $sformatf("v%0d", vecId);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge crcclk);
            st   = (cyc == 0) || (v.startMid >= 0 && idx == v.startMid);
            ordy = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            ib   = (idx < v.nBits) ? v.payload[v.nBits - 1 - idx] : 1'b0;
            applyStimulus(st, 1'b0, idx < v.nBits, ib, idx == v.nBits - 1, ordy);
            #1;
            if (afterDone) begin
                busyAfter = bus.busy;
                finished  = 1;
            end
            if (heldValid && (!bus.out_valid || bus.out_bit != heldBit)) stableErr++;
            heldValid = bus.out_valid && !bus.out_ready;
            heldBit   = bus.out_bit;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                outQ.push_back(bus.out_bit);
                residue = rxStep(residue, bus.out_bit);
            end
            if (bus.done) begin
                doneCount++;
                if (doneCyc < 0) begin
                    doneCyc    = cyc;
                    crcAtDone  = bus.crc;
                    busyAtDone = bus.busy;
                    afterDone  = 1;
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < outQ.size(); i++) begin
            if (i < v.nBits) gotPay = {gotPay[70:0], outQ[i]};
            else if (i < v.nBits + 16) gotTail = {gotTail[14:0], outQ[i]};
        end
        checkOutput({tag, " doneCount"}, doneCount, 1);
        checkOutput({tag, " outBits"}, outQ.size(), v.nBits + 16);
        checkOutput({tag, " payloadPass"}, gotPay[31:0], v.payload[31:0]);
        checkOutput({tag, " payloadHi"}, {gotPay[71:64], gotPay[63:40]}, {v.payload[71:64], v.payload[63:40]});
        checkOutput({tag, " crcFinal"}, crcAtDone, v.expCrc);
        checkOutput({tag, " tail"}, gotTail, v.expTail);
        checkOutput({tag, " residue"}, residue, 16'h1D0F);
        checkOutput({tag, " busyAtDone"}, busyAtDone, 1);
        checkOutput({tag, " busyAfterDone"}, busyAfter, 0);
        checkOutput({tag, " holdStable"}, stableErr, 0);
        if (!v.randReady) checkOutput({tag, " doneCycle"}, doneCyc, v.nBits + 17);
    endtask

    task automatic abortTest();
        localparam logic [71:0] PAY = 72'h313233343536373839;
        int idx = 0;
        int outCount = 0;
        int doneCount = 0;
        bit aborted = 0;
        bit ab;
        for (int cyc = 0; cyc < 200 && !aborted; cyc++) begin
            @(negedge crcclk);
            ab = (outCount == 72 + 6);
            applyStimulus(cyc == 0 || ab, ab, idx < 72, (idx < 72) ? PAY[71 - idx] : 1'b0, idx == 71, 1'b1);
            #1;
            if (ab) begin
                aborted = 1;
                checkOutput("abortCycleDone", bus.done, 0);
                checkOutput("abortCycleInReady", bus.in_ready, 0);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) outCount++;
        end
        checkOutput("abortReached", aborted, 1);
        @(negedge crcclk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("abortState", {bus.crc, bus.busy, bus.out_valid, bus.in_ready}, {16'hFFFF, 3'b000});
        for (int k = 0; k < 6; k++) begin
            @(negedge crcclk);
            #1;
            if (bus.done) doneCount++;
        end
        checkOutput("abortNoDone", doneCount, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic asyncResetTest();
        localparam logic [71:0] PAY = 72'h313233343536373839;
        int idx = 0;
        for (int cyc = 0; cyc < 21; cyc++) begin
            @(negedge crcclk);
            applyStimulus(cyc == 0, 1'b0, 1'b1, PAY[71 - idx], 1'b0, 1'b1);
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        checkOutput("preResetBusy", {bus.busy, bus.out_valid}, 2'b11);
        @(posedge crcclk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("asyncResetState",
                    {bus.crc, bus.out_bit, bus.out_valid, bus.in_ready, bus.busy, bus.done},
                    {16'hFFFF, 5'b00000});
        @(negedge crcclk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge crcclk);
        #1;
        checkOutput("postResetIdle", {bus.busy, bus.out_valid}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{72'h313233343536373839, 72, 1'b0, -1, 16'h29B1, 16'hD64E};
        vecs[1] = '{72'h313233343536373839, 72, 1'b1, -1, 16'h29B1, 16'hD64E};
        vecs[2] = '{72'h313233343536373839, 72, 1'b0, 20, 16'h29B1, 16'hD64E};
        vecs[3] = '{72'h0,                   1, 1'b0, -1, 16'hEFDF, 16'h1020};
        vecs[4] = '{72'h1,                   1, 1'b0, -1, 16'hFFFE, 16'h0001};
        vecs[5] = '{72'h0,                   8, 1'b1, -1, 16'hE1F0, 16'h1E0F};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge crcclk);
        #1;
        checkOutput("resetState",
                    {bus.crc, bus.out_bit, bus.out_valid, bus.in_ready, bus.busy, bus.done},
                    {16'hFFFF, 5'b00000});
        @(negedge crcclk);
        reset = 1'b0;

        // Payload offered while idle must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge crcclk);
        #1;
        checkOutput("idleIgnoresInput", {bus.in_ready, bus.out_valid, bus.busy}, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] frame vector %0d, %0d payload bits", i, vecs[i].nBits);
            runFrame(vecs[i], i);
            @(negedge crcclk);
        end

        $display("[TB] abort at counter 7");
        abortTest();

        $display("[TB] asynchronous reset mid-frame");
        asyncResetTest();
        runFrame(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
